pci_blue_arbiter: RTL and testbench
===================================

Name: pci_blue_arbiter

Overview:
- Central PCI bus arbiter that shares the PCI bus among up to NUM_MASTERS initiators, including the local pci_blue_master.
- Samples registered REQ inputs and the bus state (FRAME, IRDY) and drives one-hot GNT outputs.
- Supports round-robin fairness, hidden arbitration during busy bus, bus parking, and a grant-ignored timeout.
- Sits beside the pad ring; GNT outputs feed the pads (next-cycle registered), REQ/FRAME/IRDY arrive from pads as _prev signals, all active-high internally.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
MASTER_INDEX_WIDTH, 2, width of a master index; must satisfy 2**MASTER_INDEX_WIDTH >= NUM_MASTERS
PARK_MASTER, 0, index granted when no requests are pending and parking is enabled
GNT_TIMEOUT, 16, idle-bus clocks a granted master may take to assert FRAME

Ports:
pci_clk  input  1  PCI clock; all state updates on rising edge
pci_reset_comb  input  1  asynchronous, active-high reset
pci_req_in_prev  input  NUM_MASTERS  registered REQ per master, 1 = requesting
pci_frame_in_prev  input  1  registered FRAME, 1 = asserted
pci_irdy_in_prev  input  1  registered IRDY, 1 = asserted
arb_enable  input  1  0 = grant nothing new; an in-progress grant is withdrawn via IDLE
arb_park_enable  input  1  1 = park bus on PARK_MASTER when idle
arb_master_mask  input  NUM_MASTERS  1 = master may be granted
pci_gnt_out_next  output  NUM_MASTERS  registered GNT, one-hot or zero
arb_owner  output  MASTER_INDEX_WIDTH  index of master that started the most recent transaction
arb_owner_valid  output  1  1 once any transaction start has been seen
arb_timeout_pulse  output  1  one-clock pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, active-high): pci_gnt_out_next=0, state=IDLE, rr_ptr=0, timer=0, arb_owner=0, arb_owner_valid=0, arb_timeout_pulse=0. Asserting reset mid-grant drops GNT immediately, without waiting for a clock.
- Derived signals:
  - bus_idle = !frame & !irdy.
  - start = frame & previous-cycle bus_idle, using a registered bus_idle_d.
  - eligible = req & mask & {NUM_MASTERS{arb_enable}}.
- Winner selection: round-robin search from rr_ptr upward, wrapping mod NUM_MASTERS. The first eligible index wins.
- State IDLE (all GNT low):
  - if any eligible: GRANT(winner), timer=0.
  - else if arb_park_enable & arb_enable & mask[PARK_MASTER]: PARK.
  - else stay in IDLE.
  - Latency: a req sampled in IDLE produces GNT on the next clock.
- State GRANT(m), GNT[m]=1:
  - start: arb_owner=m, arb_owner_valid=1, rr_ptr=(m+1) mod NUM_MASTERS, then go to IDLE. This gives hidden arbitration; the next master may be granted while the bus is busy.
  - else if !eligible[m]: go to IDLE.
  - else if bus_idle and timer==GNT_TIMEOUT-1: go to IDLE, arb_timeout_pulse=1 for one clock, rr_ptr=(m+1) mod NUM_MASTERS.
  - else: timer increments only while bus_idle and holds while the bus is busy (previous owner still running). Timer saturates and never wraps.
- State PARK, GNT[PARK_MASTER]=1, no timeout:
  - start: record owner as in GRANT, then go to IDLE.
  - else if the eligible set is exactly {PARK_MASTER}: go to GRANT(PARK_MASTER) without a dead cycle.
  - else if any other master is eligible, or park/enable/mask conditions drop: go to IDLE.
- Any move of GNT from one master to another passes through IDLE, giving at least one all-zero GNT clock. GNT is never multi-hot.
- Simultaneous events: start has priority over req removal and timeout in the same cycle.
- Masters at index >= NUM_MASTERS do not exist. rr_ptr arithmetic wraps at NUM_MASTERS, not at 2**MASTER_INDEX_WIDTH.

Test Plan:
- Single request: after reset, req=0100 with FRAME low → next clock gnt=0100. FRAME asserted 3 clocks later → arb_owner=2, arb_owner_valid=1, gnt=0000 for one clock.
- Round-robin: req=1111 held, each master starts FRAME one clock after its GNT → grant order 0,1,2,3,0, with one zero-GNT clock between grants.
- Timeout: req=0010, bus idle, no FRAME → gnt=0010 for exactly 16 clocks, arb_timeout_pulse high for 1 clock, then gnt=0000. With req still high, the next grant goes to master 1 only if no other master is eligible.
- Parking: req=0000, arb_park_enable=1 → gnt=0001 held indefinitely. Then req=1000 → gnt=0000 for 1 clock, then 1000. Then req=0001 while parked → gnt stays 0001 without a gap.
- Hidden arbitration: master 0 owns a busy bus (FRAME/IRDY high for 10 clocks) while req=0100 → gnt=0100 during the busy period, timer holds at 0, and there is no timeout.
- Reset mid-grant: gnt=0010, assert pci_reset_comb between clock edges → gnt=0000 immediately, arb_owner_valid=0. Release reset with req=0010 → gnt=0010 one clock later.

Source files
------------

// File: rtl/pci_blue_arbiter.sv
// Central PCI bus arbiter: round-robin grant, hidden arbitration,
// bus parking, and a grant-ignored timeout.
//
// Ports:
//   pci_clk, pci_reset_comb        clock / async active-high reset
//   pci_req_in_prev                registered REQ per master
//   pci_frame_in_prev/irdy_in_prev registered bus state
//   arb_enable, arb_park_enable    global grant / parking enables
//   arb_master_mask                per-master grant enable
//   pci_gnt_out_next               registered one-hot (or zero) GNT
//   arb_owner, arb_owner_valid     master that started the last transaction
//   arb_timeout_pulse              one-clock pulse on grant timeout
module pci_blue_arbiter #(
  parameter int NUM_MASTERS        = 4,
  parameter int MASTER_INDEX_WIDTH = 2,
  parameter int PARK_MASTER        = 0,
  parameter int GNT_TIMEOUT        = 16
) (
  input  logic                          pci_clk,
  input  logic                          pci_reset_comb,
  input  logic [NUM_MASTERS-1:0]        pci_req_in_prev,
  input  logic                          pci_frame_in_prev,
  input  logic                          pci_irdy_in_prev,
  input  logic                          arb_enable,
  input  logic                          arb_park_enable,
  input  logic [NUM_MASTERS-1:0]        arb_master_mask,
  output logic [NUM_MASTERS-1:0]        pci_gnt_out_next,
  output logic [MASTER_INDEX_WIDTH-1:0] arb_owner,
  output logic                          arb_owner_valid,
  output logic                          arb_timeout_pulse
);

  localparam int IW = MASTER_INDEX_WIDTH;
  localparam int TW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(GNT_TIMEOUT - 1);
  localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_PARK
  } state_t;

  function automatic logic [IW-1:0] inc_wrap(
    input logic [IW-1:0] v
  );
    logic [IW:0] s;
    s = {1'b0, v} + (IW+1)'(1);
    if (s >= (IW+1)'(NUM_MASTERS)) s = '0;
    return s[IW-1:0];
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(
    input logic [IW-1:0] i
  );
    return NUM_MASTERS'(1) << i;
  endfunction

  state_t                 state_q, state_d;
  logic [IW-1:0]          m_q, m_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic                   valid_q, valid_d;
  logic                   to_q, to_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   idle_dq, idle_dd;

  logic                   bus_idle;
  logic                   start;
  logic                   park_ok;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] park_oh;
  logic                   win_found;
  logic [IW-1:0]          win_idx;

  assign bus_idle = !pci_frame_in_prev && !pci_irdy_in_prev;
  assign idle_dd  = bus_idle;
  // A transaction starts when FRAME rises on a bus that was idle.
  assign start    = pci_frame_in_prev && idle_dq;
  assign elig     = pci_req_in_prev & arb_master_mask
                  & {NUM_MASTERS{arb_enable}};
  assign park_oh  = onehot(PARK_IDX);
  assign park_ok  = arb_park_enable && arb_enable
                  && arb_master_mask[PARK_MASTER];

  // Round-robin search starting at rr_q, wrapping at NUM_MASTERS.
  always_comb begin
    logic [IW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = rr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
      idx = inc_wrap(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    owner_d = owner_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    gnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          m_d     = win_idx;
          timer_d = '0;
        end else if (park_ok) begin
          state_d = S_PARK;
        end
      end
      S_GRANT: begin
        if (start) begin
          owner_d = m_q;
          valid_d = 1'b1;
          rr_d    = inc_wrap(m_q);
          state_d = S_IDLE;
        end else if (!elig[m_q]) begin
          state_d = S_IDLE;
        end else if (bus_idle && timer_q == TMAX) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
          rr_d    = inc_wrap(m_q);
        end else if (bus_idle) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_PARK: begin
        if (start) begin
          owner_d = PARK_IDX;
          valid_d = 1'b1;
          rr_d    = inc_wrap(PARK_IDX);
          state_d = S_IDLE;
        end else if (elig == park_oh) begin
          // Parked master requests: keep GNT, no dead cycle.
          state_d = S_GRANT;
          m_d     = PARK_IDX;
          timer_d = '0;
        end else if (elig != '0 || !park_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_GRANT) gnt_d = onehot(m_d);
    else if (state_d == S_PARK) gnt_d = park_oh;
  end

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      gnt_q   <= '0;
      idle_dq <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      gnt_q   <= gnt_d;
      idle_dq <= idle_dd;
    end
  end

  assign pci_gnt_out_next  = gnt_q;
  assign arb_owner         = owner_q;
  assign arb_owner_valid   = valid_q;
  assign arb_timeout_pulse = to_q;

endmodule

// File: tb/tb_pci_blue_arbiter.sv
// Directed bench for pci_blue_arbiter: vector table plus
// hand-written timeout, hidden-arbitration and async-reset sequences.
module tb_pci_blue_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic       en;
  logic       park;
  logic [3:0] mask;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       valid;
  logic       to_pulse;

  int checks = 0;
  int errors = 0;

  pci_blue_arbiter #(
    .NUM_MASTERS(4),
    .MASTER_INDEX_WIDTH(2),
    .PARK_MASTER(0),
    .GNT_TIMEOUT(16)
  ) dut (
    .pci_clk(clk),
    .pci_reset_comb(rst),
    .pci_req_in_prev(req),
    .pci_frame_in_prev(frame),
    .pci_irdy_in_prev(irdy),
    .arb_enable(en),
    .arb_park_enable(park),
    .arb_master_mask(mask),
    .pci_gnt_out_next(gnt),
    .arb_owner(owner),
    .arb_owner_valid(valid),
    .arb_timeout_pulse(to_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       f;
    logic       i;
    logic       en;
    logic       pk;
    logic [3:0] mask;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input bit rs, input logic [3:0] rq,
    input logic f, input logic i,
    input logic e, input logic p,
    input logic [3:0] m, input logic [3:0] g,
    input logic [1:0] o, input logic v
  );
    vec_t r;
    r.rst = rs; r.req = rq; r.f = f; r.i = i;
    r.en = e; r.pk = p; r.mask = m; r.gnt = g;
    r.own = o; r.v = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(
    input logic [3:0] rq, input logic f, input logic i
  );
    req = rq;
    frame = f;
    irdy = i;
  endtask

  // Tick until GNT leaves g; gnt-high ticks must equal exp_hi.
  task automatic run_to_timeout(
    input string name, input logic [3:0] g, input int exp_hi
  );
    int hi;
    bit done;
    bit early;
    hi = 0;
    done = 0;
    early = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (gnt === g) begin
        hi++;
        if (to_pulse !== 1'b0) early = 1;
      end else begin
        done = 1;
      end
    end
    check({name, " hi_clocks"}, 32'(hi), 32'(exp_hi));
    check({name, " early_pulse"}, 32'(early), 32'd0);
    check({name, " pulse"}, 32'(to_pulse), 32'd1);
    check({name, " gnt_drop"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    en = 1'b1;
    park = 1'b0;
    mask = 4'b1111;
    tick();
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset owner", 32'(owner), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset pulse", 32'(to_pulse), 32'd0);
    tick();
    rst = 1'b0;

    // single request; start beats req removal in same clock
    vecs.push_back(mk(1, 4'b0100, 0, 0, 1, 0, 4'hf, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 1, 0, 4'hf, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 1, 0, 4'hf, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 0, 4'hf, 4'b0000, 2, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 0, 4'hf, 4'b0000, 2, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 4'hf, 4'b0000, 2, 1));
    // round robin 0,1,2,3,0
    vecs.push_back(mk(1, 4'b1111, 0, 0, 1, 0, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'hf, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 0, 4'hf, 4'b0010, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'hf, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 0, 4'hf, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'hf, 4'b0000, 2, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 0, 4'hf, 4'b1000, 2, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'hf, 4'b0000, 3, 1));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 0, 4'hf, 4'b0001, 3, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 4'hf, 4'b0000, 0, 1));
    // parking
    vecs.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 1, 4'hf, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 1, 4'hf, 4'b1000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'hf, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'hf, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 1, 1, 4'he, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 1, 1, 4'hc, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 1, 1, 4'hc, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 4'hf, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 4'hf, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 1, 4'hf, 4'b0001, 0, 1));

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      drive(vecs[n].req, vecs[n].f, vecs[n].i);
      en = vecs[n].en;
      park = vecs[n].pk;
      mask = vecs[n].mask;
      tick();
      check($sformatf("v%0d gnt", n), 32'(gnt), 32'(vecs[n].gnt));
      check($sformatf("v%0d owner", n), 32'(owner), 32'(vecs[n].own));
      check($sformatf("v%0d valid", n), 32'(valid), 32'(vecs[n].v));
      check($sformatf("v%0d pulse", n), 32'(to_pulse), 32'd0);
    end

    // timeout: master 1 ignores its grant
    en = 1'b1;
    park = 1'b0;
    mask = 4'b1111;
    drive(4'b0010, 1'b0, 1'b0);
    do_reset();
    run_to_timeout("to1", 4'b0010, 16);
    tick();
    check("to1 regrant", 32'(gnt), 32'b0010);
    check("to1 pulse_off", 32'(to_pulse), 32'd0);
    run_to_timeout("to2", 4'b0010, 15);
    req = 4'b0011;
    tick();
    check("to2 fair_next", 32'(gnt), 32'b0001);

    // hidden arbitration during a 10-clock busy bus
    drive(4'b0001, 1'b0, 1'b0);
    do_reset();
    tick();
    check("hid gnt0", 32'(gnt), 32'b0001);
    frame = 1'b1;
    tick();
    check("hid owner_valid", 32'(valid), 32'd1);
    begin
      int good;
      good = 0;
      drive(4'b0100, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++) begin
        tick();
        if (gnt === 4'b0100 && to_pulse === 1'b0) good++;
      end
      check("hid busy_gnt", 32'(good), 32'd10);
    end
    drive(4'b0100, 1'b0, 1'b0);
    run_to_timeout("hid", 4'b0100, 15);
    check("hid owner", 32'(owner), 32'd0);

    // async reset mid-grant
    drive(4'b0010, 1'b0, 1'b0);
    do_reset();
    tick();
    frame = 1'b1;
    tick();
    check("ar owner_valid", 32'(valid), 32'd1);
    frame = 1'b0;
    tick();
    check("ar gnt", 32'(gnt), 32'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("ar gnt_drop", 32'(gnt), 32'd0);
    check("ar valid_drop", 32'(valid), 32'd0);
    check("ar owner_clr", 32'(owner), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check("ar regrant", 32'(gnt), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
